// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with broadcast mode,
// one-entry output register and saturating delivery counter per channel.
module demux_1xn_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic               err_sel,
    output logic [N*CNT_W-1:0] cnt
);

    logic [N-1:0]     w_can_load;
    logic [N-1:0]     w_load;
    logic [N-1:0]     w_drain;
    logic             w_uni_ready;
    logic             w_sel_ok;
    logic             w_accept;

    logic [N-1:0]     r_valid;
    logic [WIDTH-1:0] r_data [N];
    logic [CNT_W-1:0] r_cnt  [N];
    logic             r_err;

    assign w_can_load = ~r_valid | out_ready;
    assign w_drain    = r_valid & out_ready;
    assign w_sel_ok   = ({1'b0, in_sel} < (SEL_W + 1)'(N));

    // An out-of-range select matches no channel, so the word is sunk.
    always_comb begin
        w_uni_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_uni_ready = w_can_load[i];
            end
        end
    end

    assign in_ready = in_bcast ? (&w_can_load) : w_uni_ready;
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < N; i++) begin
            w_load[i] = w_accept & (in_bcast | (in_sel == SEL_W'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_data[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_err <= w_accept & ~in_bcast & ~w_sel_ok;
            for (int i = 0; i < N; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= in_data;
                end else if (w_drain[i]) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_drain[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        cnt      = '0;
        for (int i = 0; i < N; i++) begin
            out_data[i*WIDTH +: WIDTH] = r_data[i];
            cnt[i*CNT_W +: CNT_W]      = r_cnt[i];
        end
    end

    assign out_valid = r_valid;
    assign err_sel   = r_err;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Bench for demux_1xn_stream: a 4-channel/16-bit-count and a 3-channel/
// 4-bit-count instance share one input stream against a channel-level model.
module tb_demux_1xn_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic        in_valid;

    logic [3:0]  rdy0;
    logic        rdy_in0;
    logic [31:0] od0;
    logic [3:0]  ov0;
    logic        err0;
    logic [63:0] cnt0;

    logic [2:0]  rdy1;
    logic        rdy_in1;
    logic [23:0] od1;
    logic [2:0]  ov1;
    logic        err1;
    logic [11:0] cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux_1xn_stream #(.WIDTH(8), .N(4), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(rdy_in0),
        .out_data(od0), .out_valid(ov0), .out_ready(rdy0),
        .err_sel(err0), .cnt(cnt0)
    );

    demux_1xn_stream #(.WIDTH(8), .N(3), .CNT_W(4)) u_d1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(rdy_in1),
        .out_data(od1), .out_valid(ov1), .out_ready(rdy1),
        .err_sel(err1), .cnt(cnt1)
    );

    // Model: per instance k, per channel: "holding a word", its data, count.
    bit         m_full [2][4];
    logic [7:0] m_data [2][4];
    int         m_cnt  [2][4];
    bit         m_err  [2];

    function automatic int nch(int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int cmax(int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(int k, bit [3:0] r);
        bit ok;
        if (in_bcast) begin
            ok = 1'b1;
            for (int i = 0; i < nch(k); i++)
                if (m_full[k][i] && !r[i]) ok = 1'b0;
            return ok;
        end
        if (int'(in_sel) >= nch(k)) return 1'b1;
        return !m_full[k][in_sel] || r[in_sel];
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_full[k][i] = 1'b0;
                m_data[k][i] = 8'h00;
                m_cnt[k][i]  = 0;
            end
        end
    endtask

    task automatic check_outs(string tag);
        logic [3:0]  ev0;
        logic [31:0] ed0;
        logic [63:0] ec0;
        logic [2:0]  ev1;
        logic [23:0] ed1;
        logic [11:0] ec1;
        for (int i = 0; i < 4; i++) begin
            ev0[i]        = m_full[0][i];
            ed0[i*8 +: 8] = m_data[0][i];
            ec0[i*16 +: 16] = 16'(m_cnt[0][i]);
        end
        for (int i = 0; i < 3; i++) begin
            ev1[i]        = m_full[1][i];
            ed1[i*8 +: 8] = m_data[1][i];
            ec1[i*4 +: 4] = 4'(m_cnt[1][i]);
        end
        chk({tag, ".ov0"}, 64'(ov0), 64'(ev0));
        chk({tag, ".od0"}, 64'(od0), 64'(ed0));
        chk({tag, ".cnt0"}, cnt0, ec0);
        chk({tag, ".err0"}, 64'(err0), 64'(m_err[0]));
        chk({tag, ".ov1"}, 64'(ov1), 64'(ev1));
        chk({tag, ".od1"}, 64'(od1), 64'(ed1));
        chk({tag, ".cnt1"}, 64'(cnt1), 64'(ec1));
        chk({tag, ".err1"}, 64'(err1), 64'(m_err[1]));
    endtask

    // Inputs are already set; checks in_ready, clocks once, checks outputs.
    task automatic cycle(string tag);
        bit [3:0] r [2];
        bit       acc [2];
        r[0] = rdy0;
        r[1] = {1'b0, rdy1};
        #1;
        acc[0] = in_valid && m_ready(0, r[0]);
        acc[1] = in_valid && m_ready(1, r[1]);
        chk({tag, ".rdy0"}, 64'(rdy_in0), 64'(m_ready(0, r[0])));
        chk({tag, ".rdy1"}, 64'(rdy_in1), 64'(m_ready(1, r[1])));
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < nch(k); i++) begin
                if (m_full[k][i] && r[k][i]) begin
                    m_full[k][i] = 1'b0;
                    if (m_cnt[k][i] < cmax(k)) m_cnt[k][i]++;
                end
            end
            m_err[k] = 1'b0;
            if (acc[k]) begin
                for (int i = 0; i < nch(k); i++) begin
                    if (in_bcast || int'(in_sel) == i) begin
                        m_full[k][i] = 1'b1;
                        m_data[k][i] = in_data;
                    end
                end
                if (!in_bcast && int'(in_sel) >= nch(k)) m_err[k] = 1'b1;
            end
        end
        check_outs(tag);
    endtask

    task automatic drive(bit v, bit b, logic [1:0] s, logic [7:0] d);
        in_valid = v;
        in_bcast = b;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_clear();
        check_outs("rst");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy0 = 4'hF;
        rdy1 = 3'h7;
        drive(0, 0, 2'd0, 8'h00);
        m_clear();
        #12;
        check_outs("init");
        rst = 1'b0;

        // Reset while ch2 holds a word.
        rdy0 = 4'b1011;
        rdy1 = 3'b011;
        drive(1, 0, 2'd2, 8'h5A);
        cycle("hold5a");
        drive(0, 0, 2'd0, 8'h00);
        cycle("idle");
        do_reset();
        cycle("post_rst");

        // Unicast routing.
        rdy0 = 4'hF;
        rdy1 = 3'h7;
        for (int s = 0; s < 4; s++) begin
            drive(1, 0, 2'(s), 8'(8'h11 * (s + 1)));
            cycle("uni");
        end
        drive(0, 0, 2'd0, 8'h00);
        cycle("uni_tail");
        cycle("uni_tail");

        // Backpressure on ch1.
        rdy0 = 4'b1101;
        rdy1 = 3'b101;
        drive(1, 0, 2'd1, 8'hA1);
        cycle("bp_a1");
        drive(1, 0, 2'd1, 8'hA2);
        cycle("bp_a2");
        cycle("bp_stall");
        chk("bp_hold", 64'(od0[15:8]), 64'h0A1);
        rdy0 = 4'hF;
        rdy1 = 3'h7;
        cycle("bp_go");
        chk("bp_nobubble", 64'(od0[15:8]), 64'h0A2);
        drive(0, 0, 2'd0, 8'h00);
        cycle("bp_tail");

        // Broadcast with ch2 blocked.
        rdy0 = 4'b1011;
        rdy1 = 3'b011;
        drive(1, 1, 2'd0, 8'hC3);
        cycle("bc_c3");
        drive(1, 1, 2'd0, 8'h3C);
        cycle("bc_wait");
        cycle("bc_wait");
        rdy0 = 4'hF;
        rdy1 = 3'h7;
        cycle("bc_go");
        chk("bc_all", 64'(od0), 64'h3C3C3C3C);
        drive(0, 0, 2'd0, 8'h00);
        cycle("bc_tail");

        // Invalid select on the 3-channel instance.
        drive(1, 0, 2'd3, 8'hFF);
        cycle("bad_sel");
        chk("bad_err", 64'(err1), 64'h1);
        drive(0, 0, 2'd0, 8'h00);
        cycle("bad_tail");

        // Counter saturation on the 4-bit instance.
        for (int n = 0; n < 20; n++) begin
            drive(1, 0, 2'd0, 8'(n));
            cycle("sat");
        end
        drive(0, 0, 2'd0, 8'h00);
        cycle("sat_tail");
        chk("sat_cnt", 64'(cnt1[3:0]), 64'hF);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rdy0 = 4'($urandom);
            rdy1 = 3'($urandom);
            drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7) == 0,
                  2'($urandom), 8'($urandom));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
